// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU, branch resolve, and an iterative multiply/divide unit.
// Latency: ALU/branch ops 1 edge; M ops XLEN+2 edges from presentation.
// Backpressure: stall (combinational) holds upstream while an M op is accepted or iterating.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   keep / nop                        freeze everything / flush to a bubble and abort M op
//   in_valid, op, pc, rs1, rs2, imm   operation and operands
//   src_sel, br_type, is_jalr         operand muxing and branch control
//   wreg, regwrite                    destination register and write enable
//   res_o, target_o, taken_o, valid_o, regwrite_o, wreg_o   registered results
//   stall                             upstream must hold its inputs while high
module execute_md #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keep,
  input  logic            nop,
  input  logic            in_valid,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      src_sel,
  input  logic [2:0]      br_type,
  input  logic            is_jalr,
  input  logic [4:0]      wreg,
  input  logic            regwrite,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] target_o,
  output logic            taken_o,
  output logic            valid_o,
  output logic            regwrite_o,
  output logic [4:0]      wreg_o,
  output logic            stall
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [SW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]        mop_q;     // which of the eight M ops is in flight
  logic              s1_q, s2_q, div0_q;
  logic [4:0]        mwreg_q;
  logic              mregw_q;

  // ---------------- single-cycle datapath ----------------
  logic [XLEN-1:0] a_op, b_op, alu_res, tgt_sum, target;
  logic [SW-1:0]   shamt;
  logic            is_m, legal_alu, taken;

  assign is_m      = (ENABLE_M != 0) && (op[4:3] == 2'b10);
  assign legal_alu = (op <= 5'd9);
  assign b_op      = src_sel[0] ? rs2 : imm;
  assign shamt     = b_op[SW-1:0];

  always_comb begin
    a_op = '0;
    case (src_sel[2:1])
      2'b01:   a_op = rs1;
      2'b10:   a_op = pc;
      default: a_op = '0;
    endcase
    alu_res = '0;
    case (op)
      5'd0:    alu_res = a_op + b_op;
      5'd1:    alu_res = a_op - b_op;
      5'd2:    alu_res = a_op & b_op;
      5'd3:    alu_res = a_op | b_op;
      5'd4:    alu_res = a_op ^ b_op;
      5'd5:    alu_res = a_op << shamt;
      5'd6:    alu_res = a_op >> shamt;
      5'd7:    alu_res = $unsigned($signed(a_op) >>> shamt);
      5'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
      5'd9:    alu_res = {{(XLEN-1){1'b0}}, (a_op < b_op)};
      default: alu_res = '0;
    endcase
  end

  // Branch compare always looks at rs1/rs2, independent of operand muxing.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      3'd1:    taken = (rs1 == rs2);
      3'd2:    taken = (rs1 != rs2);
      3'd3:    taken = ($signed(rs1) <  $signed(rs2));
      3'd4:    taken = ($signed(rs1) >= $signed(rs2));
      3'd5:    taken = (rs1 <  rs2);
      3'd6:    taken = (rs1 >= rs2);
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign tgt_sum = is_jalr ? (rs1 + imm) : (pc + imm);
  assign target  = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~is_jalr};

  // ---------------- M-op setup: signs and magnitudes ----------------
  logic            sgn_a, sgn_b, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;

  assign sgn_a = (op[2:0] == 3'd0) || (op[2:0] == 3'd1) || (op[2:0] == 3'd2) ||
                 (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign sgn_b = (op[2:0] == 3'd0) || (op[2:0] == 3'd1) ||
                 (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign neg1  = sgn_a & rs1[XLEN-1];
  assign neg2  = sgn_b & rs2[XLEN-1];
  assign mag1  = neg1 ? -rs1 : rs1;
  assign mag2  = neg2 ? -rs2 : rs2;

  // ---------------- one iteration of shift-add / restoring divide ----------------
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd_q});
  // When div_ge the difference is below the divisor, so the low XLEN bits are exact.
  assign div_rem  = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
  assign div_next = {div_rem, acc_q[XLEN-2:0], div_ge};

  // ---------------- final sign fix ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, m_res;

  assign prod_fix = (s1_q ^ s2_q) ? -acc_q : acc_q;
  // Divide-by-zero quotient is all ones regardless of sign; the remainder
  // naturally comes back as the dividend after its own sign fix.
  assign quo_fix  = div0_q ? '1 : ((s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem_fix  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    m_res = '0;
    case (mop_q)
      3'd0:       m_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       m_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: m_res = quo_fix;
      default:    m_res = rem_fix;
    endcase
  end

  assign stall = rst && (((state_q == IDLE) && in_valid && is_m) || (state_q == BUSY));

  // ---------------- FSM and output register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      mop_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      div0_q     <= 1'b0;
      mwreg_q    <= '0;
      mregw_q    <= 1'b0;
      res_o      <= '0;
      target_o   <= '0;
      taken_o    <= 1'b0;
      valid_o    <= 1'b0;
      regwrite_o <= 1'b0;
      wreg_o     <= '0;
    end else if (!keep) begin
      // Bubble by default; the branches below override what they produce.
      res_o      <= '0;
      target_o   <= '0;
      taken_o    <= 1'b0;
      valid_o    <= 1'b0;
      regwrite_o <= 1'b0;
      wreg_o     <= '0;
      if (nop) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid && is_m) begin
              state_q <= BUSY;
              cnt_q   <= SW'(XLEN-1);
              mop_q   <= op[2:0];
              s1_q    <= neg1;
              s2_q    <= neg2;
              div0_q  <= (rs2 == '0);
              mwreg_q <= wreg;
              mregw_q <= regwrite;
              if (op[2]) begin
                opnd_q <= mag2;
                acc_q  <= {{XLEN{1'b0}}, mag1};
              end else begin
                opnd_q <= mag1;
                acc_q  <= {{XLEN{1'b0}}, mag2};
              end
            end else if (in_valid) begin
              res_o      <= legal_alu ? alu_res : '0;
              target_o   <= target;
              taken_o    <= taken;
              valid_o    <= 1'b1;
              regwrite_o <= legal_alu & regwrite;
              wreg_o     <= wreg;
            end
          end
          BUSY: begin
            acc_q <= mop_q[2] ? div_next : mul_next;
            if (cnt_q == '0) state_q <= DONE;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          DONE: begin
            res_o      <= m_res;
            valid_o    <= 1'b1;
            regwrite_o <= mregw_q;
            wreg_o     <= mwreg_q;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_execute_md.sv
module tb_execute_md;
  logic        clk = 1'b0;
  logic        rst, keep, nop, in_valid, is_jalr, regwrite;
  logic [4:0]  op, wreg;
  logic [31:0] pc, rs1, rs2, imm;
  logic [2:0]  src_sel, br_type;
  logic [31:0] res_o, target_o;
  logic        taken_o, valid_o, regwrite_o, stall;
  logic [4:0]  wreg_o;

  int checks = 0;
  int errors = 0;

  execute_md #(.XLEN(32), .ENABLE_M(1)) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop), .in_valid(in_valid), .op(op),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .src_sel(src_sel), .br_type(br_type),
    .is_jalr(is_jalr), .wreg(wreg), .regwrite(regwrite),
    .res_o(res_o), .target_o(target_o), .taken_o(taken_o), .valid_o(valid_o),
    .regwrite_o(regwrite_o), .wreg_o(wreg_o), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  ss;
    logic [2:0]  br;
    logic        jalr;
    logic [31:0] pc, rs1, rs2, imm;
    logic [31:0] e_res;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_rw;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_a(input logic [2:0] ss, input logic [31:0] p, input logic [31:0] r1);
    case (ss[2:1])
      2'b01:   return r1;
      2'b10:   return p;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (o)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return a << (b % 32);
      5'd6: return a >> (b % 32);
      5'd7: return 32'(sa >>> (b % 32));
      5'd8: return (sa < sb) ? 32'd1 : 32'd0;
      5'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] br, input logic [31:0] x, input logic [31:0] y);
    case (br)
      3'd1: return x == y;
      3'd2: return x != y;
      3'd3: return int'(x) < int'(y);
      3'd4: return int'(x) >= int'(y);
      3'd5: return x < y;
      3'd6: return x >= y;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_m(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int ix, iy;
    logic ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    ix = int'(x);
    iy = int'(y);
    ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
    p = '0;
    case (o)
      5'd16: begin p = sx * sy; return p[31:0];  end
      5'd17: begin p = sx * sy; return p[63:32]; end
      5'd18: begin p = sx * uy; return p[63:32]; end
      5'd19: begin p = ux * uy; return p[63:32]; end
      5'd20: return (y == 0) ? 32'hFFFFFFFF : (ovf ? x : 32'(ix / iy));
      5'd21: return (y == 0) ? 32'hFFFFFFFF : x / y;
      5'd22: return (y == 0) ? x : (ovf ? 32'h0 : 32'(ix % iy));
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction

  // Present an M op and wait for its result; optionally assert keep for 5
  // cycles starting keep_at edges after presentation.
  task automatic run_m(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int keep_at, output logic [31:0] res, output int lat, output int scnt);
    op = o; rs1 = a; rs2 = b; pc = 32'h0; imm = 32'h0; src_sel = 3'b011;
    br_type = 3'd0; is_jalr = 1'b0; wreg = 5'd7; regwrite = 1'b1; in_valid = 1'b1;
    lat = 0;
    scnt = 0;
    while (lat < 200) begin
      keep = (keep_at >= 0 && lat >= keep_at && lat < keep_at + 5);
      #1;
      if (stall) scnt++;
      step();
      lat++;
      if (valid_o) break;
    end
    keep = 1'b0;
    res = res_o;
    in_valid = 1'b0;
    if (lat >= 200) chk("m_timeout", 32'(lat), 32'd0);
  endtask

  logic [31:0] r, a_v, b_v, e_res, e_tgt;
  logic        e_tk, e_rw;
  int          lat, scnt, seen;
  logic [31:0] specials [5];

  initial begin
    rst = 1'b0; keep = 1'b0; nop = 1'b0; in_valid = 1'b1; op = 5'd17;
    pc = 32'h0; rs1 = 32'h80000000; rs2 = 32'h80000000; imm = 32'h0;
    src_sel = 3'b011; br_type = 3'd0; is_jalr = 1'b0; wreg = 5'd0; regwrite = 1'b1;
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    vt[0]  = '{5'd0, 3'b010, 3'd0, 1'b0, 32'h0,    32'hFFFFFFFF, 32'h0,  32'h1,  32'h0,        1'b0, 32'h1,    1'b1};
    vt[1]  = '{5'd0, 3'b100, 3'd2, 1'b0, 32'h100,  32'h5,        32'h5,  32'h20, 32'h120,      1'b0, 32'h120,  1'b1};
    vt[2]  = '{5'd0, 3'b100, 3'd7, 1'b1, 32'h100,  32'h203,      32'h0,  32'h0,  32'h100,      1'b1, 32'h202,  1'b1};
    vt[3]  = '{5'd1, 3'b011, 3'd3, 1'b0, 32'h0,    32'd10,       32'd20, 32'h0,  32'hFFFFFFF6, 1'b1, 32'h0,    1'b1};
    vt[4]  = '{5'd7, 3'b011, 3'd6, 1'b0, 32'h0,    32'h80000000, 32'h24, 32'h0,  32'hF8000000, 1'b1, 32'h0,    1'b1};
    vt[5]  = '{5'd6, 3'b011, 3'd4, 1'b0, 32'h0,    32'h80000000, 32'h24, 32'h0,  32'h08000000, 1'b0, 32'h0,    1'b1};
    vt[6]  = '{5'd5, 3'b010, 3'd1, 1'b0, 32'h10,   32'h1,        32'h1,  32'h1F, 32'h80000000, 1'b1, 32'h2F,   1'b1};
    vt[7]  = '{5'd8, 3'b011, 3'd5, 1'b0, 32'h0,    32'hFFFFFFFF, 32'h1,  32'h0,  32'h1,        1'b0, 32'h0,    1'b1};
    vt[8]  = '{5'd9, 3'b011, 3'd3, 1'b0, 32'h0,    32'hFFFFFFFF, 32'h1,  32'h0,  32'h0,        1'b1, 32'h0,    1'b1};
    vt[9]  = '{5'd2, 3'b001, 3'd0, 1'b0, 32'h0,    32'h55,       32'hFF, 32'h0,  32'h0,        1'b0, 32'h0,    1'b1};
    vt[10] = '{5'd3, 3'b011, 3'd0, 1'b0, 32'h0,    32'hF0,       32'h0F, 32'h0,  32'hFF,       1'b0, 32'h0,    1'b1};
    vt[11] = '{5'd4, 3'b010, 3'd0, 1'b0, 32'h0,    32'hFF,       32'h0,  32'h0F, 32'hF0,       1'b0, 32'hF,    1'b1};
    vt[12] = '{5'd12,3'b011, 3'd0, 1'b0, 32'h0,    32'h3,        32'h4,  32'h0,  32'h0,        1'b0, 32'h0,    1'b0};
    vt[13] = '{5'd0, 3'b101, 3'd0, 1'b0, 32'h1000, 32'h0,        32'h10, 32'h0,  32'h1010,     1'b0, 32'h1000, 1'b1};

    // Reset state, with an M op presented: stall must stay low.
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_res", res_o, 32'h0);
    #20;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_valid", 32'(valid_o), 32'd0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 14; i++) begin
      op = vt[i].op; src_sel = vt[i].ss; br_type = vt[i].br; is_jalr = vt[i].jalr;
      pc = vt[i].pc; rs1 = vt[i].rs1; rs2 = vt[i].rs2; imm = vt[i].imm;
      in_valid = 1'b1; regwrite = 1'b1; wreg = 5'(i + 1);
      step();
      chk($sformatf("vec%0d_res", i), res_o, vt[i].e_res);
      chk($sformatf("vec%0d_taken", i), 32'(taken_o), 32'(vt[i].e_tk));
      chk($sformatf("vec%0d_target", i), target_o, vt[i].e_tgt);
      chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'd1);
      chk($sformatf("vec%0d_regwrite", i), 32'(regwrite_o), 32'(vt[i].e_rw));
      chk($sformatf("vec%0d_wreg", i), 32'(wreg_o), 32'(i + 1));
    end

    // Bubble, keep on a valid output, nop flush.
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 32'(valid_o), 32'd0);
    chk("bubble_res", res_o, 32'h0);
    op = 5'd0; src_sel = 3'b011; rs1 = 32'd1; rs2 = 32'd2; in_valid = 1'b1;
    step();
    chk("add_res", res_o, 32'd3);
    keep = 1'b1; rs1 = 32'd100;
    step();
    chk("keep_res", res_o, 32'd3);
    chk("keep_valid", 32'(valid_o), 32'd1);
    keep = 1'b0; nop = 1'b1;
    step();
    chk("nop_valid", 32'(valid_o), 32'd0);
    chk("nop_res", res_o, 32'h0);
    chk("nop_wreg", 32'(wreg_o), 32'd0);
    nop = 1'b0; in_valid = 1'b0;
    step();

    // Directed M ops.
    run_m(5'd17, 32'h80000000, 32'h80000000, -1, r, lat, scnt);
    chk("mulh_res", r, 32'h40000000);
    chk("mulh_lat", 32'(lat), 32'd34);
    chk("mulh_stall_cycles", 32'(scnt), 32'd33);
    chk("mulh_regwrite", 32'(regwrite_o), 32'd1);
    chk("mulh_wreg", 32'(wreg_o), 32'd7);
    run_m(5'd20, 32'h80000000, 32'hFFFFFFFF, -1, r, lat, scnt);
    chk("div_ovf", r, 32'h80000000);
    run_m(5'd22, 32'h80000000, 32'hFFFFFFFF, -1, r, lat, scnt);
    chk("rem_ovf", r, 32'h0);
    run_m(5'd21, 32'h12345678, 32'h0, -1, r, lat, scnt);
    chk("divu_by0", r, 32'hFFFFFFFF);
    run_m(5'd22, 32'd7, 32'h0, -1, r, lat, scnt);
    chk("rem_by0", r, 32'd7);
    run_m(5'd22, 32'hFFFFFFF9, 32'd2, -1, r, lat, scnt);
    chk("rem_neg", r, 32'hFFFFFFFF);

    // keep for 5 cycles during BUSY delays the result by 5.
    run_m(5'd21, 32'd1000, 32'd7, 3, r, lat, scnt);
    chk("keep_busy_res", r, 32'd142);
    chk("keep_busy_lat", 32'(lat), 32'd39);

    // Random M ops against the model.
    for (int i = 0; i < 30; i++) begin
      logic [4:0] o;
      o = 5'(16 + $urandom_range(0, 7));
      a_v = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b_v = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      run_m(o, a_v, b_v, -1, r, lat, scnt);
      chk($sformatf("rand_m%0d_op%0d_%h_%h", i, o, a_v, b_v), r, ref_m(o, a_v, b_v));
      chk($sformatf("rand_m%0d_lat", i), 32'(lat), 32'd34);
    end

    // nop during BUSY aborts the divide.
    op = 5'd20; rs1 = 32'd100; rs2 = 32'd7; src_sel = 3'b011; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("busy_stall", 32'(stall), 32'd1);
    chk("busy_valid", 32'(valid_o), 32'd0);
    nop = 1'b1; in_valid = 1'b0;
    step();
    nop = 1'b0;
    chk("nop_busy_valid", 32'(valid_o), 32'd0);
    chk("nop_busy_stall", 32'(stall), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_o) seen++;
    end
    chk("nop_abort_novalid", 32'(seen), 32'd0);

    // Async reset mid-MUL, then ADD with one-edge latency.
    op = 5'd16; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mul_busy_stall", 32'(stall), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_res", res_o, 32'h0);
    #1;
    rst = 1'b1; op = 5'd0; rs1 = 32'd40; rs2 = 32'd2; in_valid = 1'b1;
    step();
    chk("postrst_add_res", res_o, 32'd42);
    chk("postrst_add_valid", 32'(valid_o), 32'd1);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("async_rst_res", res_o, 32'h0);
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    #1 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_o) seen++;
    end
    chk("rst_discard_novalid", 32'(seen), 32'd0);

    // Random single-cycle ops (including illegal codes and bubbles).
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 15)); src_sel = 3'($urandom_range(0, 7));
      br_type = 3'($urandom_range(0, 7)); is_jalr = 1'($urandom_range(0, 1));
      pc = $urandom; rs1 = ($urandom_range(0, 3) == 0) ? rs2 : $urandom;
      rs2 = $urandom; imm = $urandom; regwrite = 1'($urandom_range(0, 1));
      wreg = 5'($urandom_range(0, 31)); in_valid = ($urandom_range(0, 7) != 0);
      a_v = ref_a(src_sel, pc, rs1);
      b_v = src_sel[0] ? rs2 : imm;
      e_res = (in_valid && op <= 9) ? ref_alu(op, a_v, b_v) : 32'h0;
      e_tk  = in_valid && ref_taken(br_type, rs1, rs2);
      e_tgt = !in_valid ? 32'h0 : (is_jalr ? ((rs1 + imm) & 32'hFFFFFFFE) : (pc + imm));
      e_rw  = in_valid && (op <= 9) && regwrite;
      step();
      chk($sformatf("rand%0d_res_op%0d", i, op), res_o, e_res);
      chk($sformatf("rand%0d_taken", i), 32'(taken_o), 32'(e_tk));
      chk($sformatf("rand%0d_target", i), target_o, e_tgt);
      chk($sformatf("rand%0d_valid", i), 32'(valid_o), 32'(in_valid));
      chk($sformatf("rand%0d_regwrite", i), 32'(regwrite_o), 32'(e_rw));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
